// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one EXU request at a time, drives the memory stage, and returns a registered result to WBU.
// Latency: accept T0, memory enable from T1, result valid the cycle after mem_ready (T3 with a 1-cycle memory).
// Backpressure: in_ready only in IDLE; RESP holds its outputs until out_ready; a missing mem_ready ends in an error after TIMEOUT cycles.
module ysyx_24080014_lsu #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q, cnt_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [7:0]  wmask_q;
    logic        store_q, err_q;

    logic        req_illegal, req_misal, req_err, req_nop, req_store;
    logic [7:0]  req_wmask;
    logic [31:0] req_wdata;
    logic [31:0] ld_word, ld_ext;
    logic        accept, done, timeout;

    // Decode the incoming request: error checks, store mask and lane-aligned store data.
    always_comb begin
        req_illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
        req_misal   = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        req_err     = req_illegal || req_misal;
        req_nop     = !in_ren && !in_wen;
        // A request with both enables set is handled as a load.
        req_store   = in_wen && !in_ren;
        case (in_funct3[1:0])
            2'b00:   req_wmask = 8'h01 << in_addr[1:0];
            2'b01:   req_wmask = 8'h03 << in_addr[1:0];
            default: req_wmask = 8'h0F;
        endcase
        req_wdata   = in_wdata << {in_addr[1:0], 3'b000};
    end

    // Shift the raw word down to the addressed lane and extend per access size.
    always_comb begin
        ld_word = mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b100:  ld_ext = {24'h0, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b101:  ld_ext = {16'h0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and handshake/enable outputs; outputs are forced low while reset is asserted.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = (req_err || req_nop) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_ren = !store_q;
                mem_wen = store_q;
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1))) begin
                    timeout = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, access cycle counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            wmask_q <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= in_addr;
            f3_q    <= in_funct3;
            rd_q    <= in_rd;
            store_q <= req_store;
            wdata_q <= (req_store && !req_err) ? req_wdata : 32'h0;
            wmask_q <= (req_store && !req_err) ? req_wmask : 8'h00;
            err_q   <= req_err;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 32'd1;
            if (done && !store_q) rdata_q <= ld_ext;
            if (timeout)          err_q   <= 1'b1;
        end
    end

    assign mem_raddr = {addr_q[31:2], 2'b00};
    assign mem_waddr = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign out_rdata = rdata_q;
    assign out_rd    = rd_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed bench for ysyx_24080014_lsu: stores, loads with extension, errors, timeout, backpressure, reset.
// Inputs driven and outputs sampled on the falling edge.
// The bench plays the memory stage by hand, raising mem_ready in the cycle it chooses.
module tb_ysyx_24080014_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ren = 1'b0, in_wen = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        out_ready = 1'b0, mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        in_ready, out_valid, out_err, mem_ren, mem_wen;
    logic [31:0] out_rdata, mem_raddr, mem_waddr, mem_wdata;
    logic [4:0]  out_rd;
    logic [7:0]  mem_wmask;

    int total = 0;
    int bad   = 0;
    int n;

    ysyx_24080014_lsu #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_err(out_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge, let it be accepted, return one cycle later (T1).
    task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd;
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    endtask

    // Called at T1: memory answers in T2; returns at T3.
    task automatic mem_answer(input string tag, input logic exp_ren, input logic exp_wen,
                              input logic [31:0] word);
        chk({tag, "_ren_t1"}, mem_ren, exp_ren);
        chk({tag, "_wen_t1"}, mem_wen, exp_wen);
        chk({tag, "_ovld_t1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_en_t2"}, mem_ren | mem_wen, 1);
        mem_ready = 1'b1; mem_rdata = word;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    // Check the response, then complete the output handshake.
    task automatic resp(input string tag, input logic [31:0] rdata, input logic [4:0] rd,
                        input logic err);
        chk({tag, "_ovld"}, out_valid, 1);
        chk({tag, "_rdata"}, out_rdata, rdata);
        chk({tag, "_rd"}, out_rd, rd);
        chk({tag, "_err"}, out_err, err);
        chk({tag, "_en_off"}, mem_ren | mem_wen, 0);
        chk({tag, "_inrdy_resp"}, in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ovld_after"}, out_valid, 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_en", mem_ren | mem_wen, 0);
        chk("rst_wmask", mem_wmask, 0);
        chk("rst_rdata", out_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // SW aligned
        issue(0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 5'd5);
        chk("sw_waddr", mem_waddr, 32'h80000004);
        chk("sw_wmask", mem_wmask, 8'h0F);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        mem_answer("sw", 0, 1, 32'h0);
        resp("sw", 32'h0, 5'd5, 0);

        // SB to top byte lane
        issue(0, 1, 3'b000, 32'h80000003, 32'h000000AB, 5'd6);
        chk("sb_waddr", mem_waddr, 32'h80000000);
        chk("sb_wmask", mem_wmask, 8'h08);
        chk("sb_wdata", mem_wdata, 32'hAB000000);
        mem_answer("sb", 0, 1, 32'h0);
        resp("sb", 32'h0, 5'd6, 0);

        // SH upper half
        issue(0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 5'd7);
        chk("sh_wmask", mem_wmask, 8'h0C);
        chk("sh_wdata", mem_wdata, 32'hBEEF0000);
        mem_answer("sh", 0, 1, 32'h0);
        resp("sh", 32'h0, 5'd7, 0);

        // Loads with extension
        issue(1, 0, 3'b000, 32'h80000002, 32'h0, 5'd8);
        chk("lb_raddr", mem_raddr, 32'h80000000);
        mem_answer("lb", 1, 0, 32'h12807654);
        resp("lb", 32'hFFFFFF80, 5'd8, 0);

        issue(1, 0, 3'b100, 32'h80000002, 32'h0, 5'd9);
        mem_answer("lbu", 1, 0, 32'h12807654);
        resp("lbu", 32'h00000080, 5'd9, 0);

        issue(1, 0, 3'b101, 32'h80000002, 32'h0, 5'd10);
        mem_answer("lhu", 1, 0, 32'h12807654);
        resp("lhu", 32'h00001280, 5'd10, 0);

        issue(1, 0, 3'b001, 32'h80000000, 32'h0, 5'd11);
        mem_answer("lh", 1, 0, 32'h1234F00D);
        resp("lh", 32'hFFFFF00D, 5'd11, 0);

        issue(1, 0, 3'b010, 32'h80000008, 32'h0, 5'd12);
        chk("lw_raddr", mem_raddr, 32'h80000008);
        mem_answer("lw", 1, 0, 32'hCAFEF00D);
        resp("lw", 32'hCAFEF00D, 5'd12, 0);

        // Both enables set behaves as a load
        issue(1, 1, 3'b010, 32'h80000010, 32'h55555555, 5'd13);
        mem_answer("rw", 1, 0, 32'h0BADC0DE);
        resp("rw", 32'h0BADC0DE, 5'd13, 0);

        // Misaligned LW: error one cycle after acceptance, no memory access
        issue(1, 0, 3'b010, 32'h80000002, 32'h0, 5'd14);
        chk("lwmis_ren", mem_ren, 0);
        resp("lwmis", 32'h0, 5'd14, 1);

        // Illegal funct3
        issue(1, 0, 3'b011, 32'h80000000, 32'h0, 5'd15);
        resp("ill", 32'h0, 5'd15, 1);

        // No-op request
        issue(0, 0, 3'b010, 32'h80000000, 32'h0, 5'd16);
        resp("nop", 32'h0, 5'd16, 0);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("idle_mrdy_ovld", out_valid, 0);
        chk("idle_mrdy_inrdy", in_ready, 1);

        // Timeout: count ACCESS cycles with mem_ready held low
        issue(1, 0, 3'b010, 32'h80000020, 32'h0, 5'd17);
        n = 0;
        while (mem_ren && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, 64);
        chk("tmo_ren", mem_ren, 0);
        resp("tmo", 32'h0, 5'd17, 1);

        // Backpressure: hold result for 10 cycles
        issue(1, 0, 3'b010, 32'h80000024, 32'h0, 5'd18);
        mem_answer("bp", 1, 0, 32'hA5A5_1234);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_ovld", out_valid, 1);
            chk("bp_hold_rdata", out_rdata, 32'hA5A51234);
            chk("bp_hold_inrdy", in_ready, 0);
            @(negedge clk);
        end
        resp("bp", 32'hA5A51234, 5'd18, 0);

        // Reset mid-ACCESS: enable drops at once
        issue(1, 0, 3'b010, 32'h80000028, 32'h0, 5'd19);
        chk("rstacc_ren_before", mem_ren, 1);
        rst = 1'b0;
        #1;
        chk("rstacc_ren", mem_ren, 0);
        chk("rstacc_inrdy", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstacc_idle", in_ready, 1);
        @(negedge clk);
        chk("rstacc_ovld", out_valid, 0);

        // Reset mid-RESP: out_valid drops at once
        issue(0, 0, 3'b000, 32'h0, 32'h0, 5'd20);
        chk("rstresp_ovld_before", out_valid, 1);
        rst = 1'b0;
        #1;
        chk("rstresp_ovld", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstresp_idle", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
